// File: rtl/game_state_ctrl.sv
// Frame-rate game supervisor: ATTRACT/PLAY/PAUSE/DYING/OVER sequencing, climb-based
// scoring with high score, and restart/freeze control of the player block.
module game_state_ctrl #(
  parameter int         START_Y      = 460,
  parameter int         Y_MAX        = 479,
  parameter int         SCORE_SHIFT  = 3,
  parameter int         DEATH_FRAMES = 60,
  parameter logic [7:0] KEY_START    = 8'h2C,
  parameter logic [7:0] KEY_PAUSE    = 8'h13
) (
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [10:0] BallY,
  input  logic        gg,
  output logic [1:0]  game_state,
  output logic        ball_reset,
  output logic        freeze,
  output logic [15:0] score,
  output logic [15:0] high_score
);

  localparam int CNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_DEATH = CNT_W'(DEATH_FRAMES - 1);

  typedef enum logic [2:0] {
    S_ATTRACT, S_PLAY, S_PAUSE, S_DYING, S_OVER
  } state_t;

  state_t           state;
  logic [7:0]       key_prev;
  logic [9:0]       best_y;
  logic [19:0]      height;
  logic [CNT_W-1:0] death_cnt;
  logic             armed;

  logic [9:0]  y;
  logic        climb;
  logic [9:0]  diff;
  logic [20:0] sum;
  logic [19:0] height_next;
  logic [19:0] score_full;
  logic [15:0] score_next;
  logic        start_ev;
  logic        pause_ev;
  logic        unused_bally_msb;

  assign y                = BallY[9:0];
  assign unused_bally_msb = BallY[10];

  // The guard makes best_y - y strictly positive, so the 10-bit difference never wraps.
  assign climb       = (y <= 10'(Y_MAX)) && (y < best_y);
  assign diff        = best_y - y;
  assign sum         = {1'b0, height} + {11'd0, diff};
  assign height_next = climb ? (sum[20] ? 20'hFFFFF : sum[19:0]) : height;
  assign score_full  = height_next >> SCORE_SHIFT;
  assign score_next  = (score_full > 20'h0FFFF) ? 16'hFFFF : score_full[15:0];

  // A held key never restarts a game: start needs a fresh press while armed.
  assign start_ev = (keycode == KEY_START) && (key_prev != KEY_START) && armed;
  assign pause_ev = (keycode == KEY_PAUSE) && (key_prev != KEY_PAUSE);

  // NOTE: every register here, including outputs, uses non-blocking assignment so all
  // updates take the values sampled at the same edge; later assignments override earlier.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_ATTRACT;
      game_state <= 2'd0;
      ball_reset <= 1'b1;
      freeze     <= 1'b1;
      score      <= 16'd0;
      high_score <= 16'd0;
      key_prev   <= 8'd0;
      best_y     <= 10'(START_Y);
      height     <= 20'd0;
      death_cnt  <= '0;
      armed      <= 1'b0;
    end else begin
      key_prev <= keycode;
      if (keycode == 8'd0) armed <= 1'b1;

      case (state)
        S_ATTRACT, S_OVER: begin
          if (start_ev) begin
            state      <= S_PLAY;
            armed      <= 1'b0;
            game_state <= 2'd1;
            ball_reset <= 1'b1;
            freeze     <= 1'b0;
            best_y     <= 10'(START_Y);
            height     <= 20'd0;
            score      <= 16'd0;
          end
        end

        S_PLAY: begin
          ball_reset <= 1'b0;
          height     <= height_next;
          score      <= score_next;
          if (climb) best_y <= y;
          if (gg) begin
            state      <= S_DYING;
            armed      <= 1'b0;
            game_state <= 2'd2;
            freeze     <= 1'b0;
            death_cnt  <= '0;
          end else if (pause_ev) begin
            state      <= S_PAUSE;
            armed      <= 1'b0;
            game_state <= 2'd2;
            freeze     <= 1'b1;
          end
        end

        S_PAUSE: begin
          if (pause_ev) begin
            state      <= S_PLAY;
            armed      <= 1'b0;
            game_state <= 2'd1;
            freeze     <= 1'b0;
            ball_reset <= 1'b0;
          end
        end

        S_DYING: begin
          death_cnt <= death_cnt + CNT_W'(1);
          if (death_cnt == LAST_DEATH) begin
            state      <= S_OVER;
            armed      <= 1'b0;
            game_state <= 2'd3;
            freeze     <= 1'b1;
            ball_reset <= 1'b1;
            if (score > high_score) high_score <= score;
          end
        end

        default: state <= S_ATTRACT;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: a frame-level behavioural model is compared against
// the outputs on every falling edge, plus hand-computed literal checkpoints.
module tb_game_state_ctrl;

  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [10:0] BallY;
  logic        gg;
  logic [1:0]  game_state;
  logic        ball_reset;
  logic        freeze;
  logic [15:0] score;
  logic [15:0] high_score;

  int checks = 0;
  int errors = 0;

  game_state_ctrl dut (
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .BallY      (BallY),
    .gg         (gg),
    .game_state (game_state),
    .ball_reset (ball_reset),
    .freeze     (freeze),
    .score      (score),
    .high_score (high_score)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Model modes: what the game is doing, independent of any encoding in the design.
  localparam int M_ATTRACT = 0, M_PLAY = 1, M_PAUSE = 2, M_DYING = 3, M_OVER = 4;

  int         m_mode;
  int         m_best;
  int         m_height;
  int         m_score;
  int         m_high;
  int         m_frames_dying;
  bit         m_armed;
  bit         m_first;
  logic [7:0] m_kprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_ATTRACT; m_best = 460; m_height = 0; m_score = 0; m_high = 0;
    m_frames_dying = 0; m_armed = 0; m_first = 0; m_kprev = 8'd0;
  endtask

  task automatic model_edge(input logic [7:0] k, input logic [10:0] by, input logic g);
    int  old_mode;
    int  yy;
    bit  start;
    bit  pause;
    old_mode = m_mode;
    start = (k == 8'h2C) && (m_kprev != 8'h2C) && m_armed;
    pause = (k == 8'h13) && (m_kprev != 8'h13);
    yy = by % 1024;
    case (m_mode)
      M_ATTRACT, M_OVER: if (start) begin
        m_mode = M_PLAY; m_first = 1; m_best = 460; m_height = 0; m_score = 0;
      end
      M_PLAY: begin
        m_first = 0;
        if (yy <= 479 && yy < m_best) begin
          m_height = m_height + (m_best - yy);
          if (m_height > 1048575) m_height = 1048575;
          m_best = yy;
        end
        m_score = m_height / 8;
        if (m_score > 65535) m_score = 65535;
        if (g) begin m_mode = M_DYING; m_frames_dying = 0; end
        else if (pause) m_mode = M_PAUSE;
      end
      M_PAUSE: if (pause) begin m_mode = M_PLAY; m_first = 0; end
      M_DYING: begin
        m_frames_dying++;
        if (m_frames_dying == 60) begin
          m_mode = M_OVER;
          if (m_score > m_high) m_high = m_score;
        end
      end
      default: ;
    endcase
    if (m_mode != old_mode) m_armed = 0;
    else if (k == 8'd0)     m_armed = 1;
    m_kprev = k;
  endtask

  function automatic int exp_gs();
    if (m_mode == M_OVER) return 3;
    if (m_mode == M_PAUSE || m_mode == M_DYING) return 2;
    return m_mode;
  endfunction

  function automatic int exp_br();
    return (m_mode == M_ATTRACT || m_mode == M_OVER || (m_mode == M_PLAY && m_first)) ? 1 : 0;
  endfunction

  function automatic int exp_fr();
    return (m_mode == M_ATTRACT || m_mode == M_PAUSE || m_mode == M_OVER) ? 1 : 0;
  endfunction

  always @(negedge frame_clk) begin
    check("cyc_game_state", 32'(game_state), 32'(exp_gs()));
    check("cyc_ball_reset", 32'(ball_reset), 32'(exp_br()));
    check("cyc_freeze",     32'(freeze),     32'(exp_fr()));
    check("cyc_score",      32'(score),      32'(m_score));
    check("cyc_high_score", 32'(high_score), 32'(m_high));
  end

  // Drive one frame, advance the model at the rising edge, return at the falling edge.
  task automatic step(input logic [7:0] k, input logic [10:0] by, input logic g);
    keycode = k; BallY = by; gg = g;
    @(posedge frame_clk);
    model_edge(k, by, g);
    @(negedge frame_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; keycode = 8'd0; BallY = 11'd460; gg = 1'b0;
    model_reset();
    #2;
    check("rst_game_state", 32'(game_state), 32'd0);
    check("rst_ball_reset", 32'(ball_reset), 32'd1);
    check("rst_freeze",     32'(freeze),     32'd1);
    check("rst_score",      32'(score),      32'd0);
    check("rst_high_score", 32'(high_score), 32'd0);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Arm, then start.
    step(8'h00, 11'd460, 1'b0);
    step(8'h00, 11'd460, 1'b0);
    step(8'h2C, 11'd460, 1'b0);
    check("start_gs",  32'(game_state), 32'd1);
    check("start_br",  32'(ball_reset), 32'd1);
    check("start_sc",  32'(score),      32'd0);
    step(8'h00, 11'd460, 1'b0);
    check("play_br_low", 32'(ball_reset), 32'd0);

    // Climb 20, none, 40 -> height 60, score 7; off-screen value ignored.
    step(8'h00, 11'd440, 1'b0);
    step(8'h00, 11'd450, 1'b0);
    step(8'h00, 11'd400, 1'b0);
    check("climb_score", 32'(score), 32'd7);
    step(8'h00, 11'd1020, 1'b0);
    check("offscreen_score", 32'(score), 32'd7);

    // Pause, move while paused, resume at the same height.
    step(8'h13, 11'd400, 1'b0);
    check("pause_gs", 32'(game_state), 32'd2);
    check("pause_fr", 32'(freeze),     32'd1);
    step(8'h13, 11'd300, 1'b0);
    step(8'h00, 11'd200, 1'b0);
    check("pause_score_held", 32'(score), 32'd7);
    step(8'h00, 11'd400, 1'b0);
    step(8'h13, 11'd400, 1'b0);
    check("resume_gs", 32'(game_state), 32'd1);
    check("resume_br", 32'(ball_reset), 32'd0);
    step(8'h00, 11'd400, 1'b0);

    // gg beats a simultaneous pause press; start key held through death.
    step(8'h13, 11'd400, 1'b1);
    check("dying_gs", 32'(game_state), 32'd2);
    check("dying_fr", 32'(freeze),     32'd0);
    for (int i = 0; i < 59; i++) step(8'h2C, 11'd400, 1'b0);
    check("dying_59_gs", 32'(game_state), 32'd2);
    step(8'h2C, 11'd400, 1'b0);
    check("over_gs",   32'(game_state), 32'd3);
    check("over_high", 32'(high_score), 32'd7);
    for (int i = 0; i < 3; i++) step(8'h2C, 11'd400, 1'b0);
    check("held_key_stays_over", 32'(game_state), 32'd3);

    // Restart and a second, lower-scoring game.
    step(8'h00, 11'd460, 1'b0);
    step(8'h2C, 11'd460, 1'b0);
    check("restart_gs",   32'(game_state), 32'd1);
    check("restart_sc",   32'(score),      32'd0);
    check("restart_high", 32'(high_score), 32'd7);
    check("restart_br",   32'(ball_reset), 32'd1);
    step(8'h00, 11'd460, 1'b0);
    step(8'h00, 11'd420, 1'b0);
    check("game2_score", 32'(score), 32'd5);
    step(8'h00, 11'd420, 1'b1);
    for (int i = 0; i < 60; i++) step(8'h00, 11'd420, 1'b0);
    check("game2_over_gs",   32'(game_state), 32'd3);
    check("game2_over_high", 32'(high_score), 32'd7);

    // Third game, then asynchronous reset between edges.
    step(8'h00, 11'd460, 1'b0);
    step(8'h2C, 11'd460, 1'b0);
    step(8'h00, 11'd380, 1'b0);
    check("game3_score", 32'(score), 32'd10);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("async_gs",   32'(game_state), 32'd0);
    check("async_br",   32'(ball_reset), 32'd1);
    check("async_fr",   32'(freeze),     32'd1);
    check("async_sc",   32'(score),      32'd0);
    check("async_high", 32'(high_score), 32'd0);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Not armed after reset: a fresh start press alone must not start a game.
    step(8'h2C, 11'd460, 1'b0);
    check("unarmed_start_gs", 32'(game_state), 32'd0);
    step(8'h00, 11'd460, 1'b0);
    step(8'h2C, 11'd460, 1'b0);
    check("post_reset_start_gs", 32'(game_state), 32'd1);
    step(8'h00, 11'd460, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
